id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the ARM pipeline. It captures the gated control bundle from the control-unit mux, plus operand data and the destination register address, at each clock edge. It presents that state to the execute stage for one full cycle. It supports hazard-unit stall (hold) and flush (bubble insertion), and tracks a valid bit so that downstream write enables are never asserted for a bubble.

---
 rtl/id_ex_pipe_reg.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register for the ARM pipeline.
// Captures the gated control bundle, operands and destination register from
// decode and presents them to execute for one full cycle. Flush loads a
// bubble, stall holds all state, and a valid bit keeps bubbles from ever
// asserting downstream write enables.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the saturating
// bubble_count output.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      reg_write_enable_in,
    input  logic                      mem_write_enable_in,
    input  logic                      mem_to_reg_select_in,
    input  logic                      alu_src_select_in,
    input  logic                      pc_src_select_in,
    input  logic [1:0]                status_bits_in,
    input  logic [1:0]                alu_control_in,
    input  logic [DATA_WIDTH-1:0]     rn_data_in,
    input  logic [DATA_WIDTH-1:0]     rm_data_in,
    input  logic [DATA_WIDTH-1:0]     imm_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
    output logic                      valid_out,
    output logic                      reg_write_enable_out,
    output logic                      mem_write_enable_out,
    output logic                      mem_to_reg_select_out,
    output logic                      alu_src_select_out,
    output logic                      pc_src_select_out,
    output logic [1:0]                status_bits_out,
    output logic [1:0]                alu_control_out,
    output logic [DATA_WIDTH-1:0]     rn_data_out,
    output logic [DATA_WIDTH-1:0]     rm_data_out,
    output logic [DATA_WIDTH-1:0]     imm_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_out
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      bubble_count
`endif
);

    // Occupancy of the stage: EMPTY holds a bubble, FULL holds a real instruction
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } validState_t;

    validState_t                r_state;
    validState_t                w_nextState;

    // Edge classification shared by the state machine, control and counter
    logic                       w_loadEdge;
    logic                       w_loadValid;
    logic                       w_loadBubble;

    // Stored control bundle
    logic                       r_regWriteEnable;
    logic                       r_memWriteEnable;
    logic                       r_memToRegSelect;
    logic                       r_aluSrcSelect;
    logic                       r_pcSrcSelect;
    logic [1:0]                 r_statusBits;
    logic [1:0]                 r_aluControl;

    // Stored operands and destination
    logic [DATA_WIDTH-1:0]      r_rnData;
    logic [DATA_WIDTH-1:0]      r_rmData;
    logic [DATA_WIDTH-1:0]      r_imm;
    logic [REG_ADDR_WIDTH-1:0]  r_rdAddr;

    // Flush wins over stall; anything else is a normal load
    assign w_loadEdge   = !flush && !stall;
    assign w_loadValid  = w_loadEdge && valid_in;
    assign w_loadBubble = flush || (w_loadEdge && !valid_in);

    // State register for the valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: flush or bubble load empties, valid load fills, stall holds
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = EMPTY;
        end else if (!stall) begin
            w_nextState = valid_in ? FULL : EMPTY;
        end
    end

    // Control bundle register: only a valid load captures real control values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regWriteEnable <= 1'b0;
            r_memWriteEnable <= 1'b0;
            r_memToRegSelect <= 1'b0;
            r_aluSrcSelect   <= 1'b0;
            r_pcSrcSelect    <= 1'b0;
            r_statusBits     <= 2'b00;
            r_aluControl     <= 2'b00;
        end else if (w_loadBubble) begin
            r_regWriteEnable <= 1'b0;
            r_memWriteEnable <= 1'b0;
            r_memToRegSelect <= 1'b0;
            r_aluSrcSelect   <= 1'b0;
            r_pcSrcSelect    <= 1'b0;
            r_statusBits     <= 2'b00;
            r_aluControl     <= 2'b00;
        end else if (w_loadValid) begin
            r_regWriteEnable <= reg_write_enable_in;
            r_memWriteEnable <= mem_write_enable_in;
            r_memToRegSelect <= mem_to_reg_select_in;
            r_aluSrcSelect   <= alu_src_select_in;
            r_pcSrcSelect    <= pc_src_select_in;
            r_statusBits     <= status_bits_in;
            r_aluControl     <= alu_control_in;
        end
    end

    // Operand register: cleared by flush, held by stall, loaded even for bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnData <= '0;
            r_rmData <= '0;
            r_imm    <= '0;
            r_rdAddr <= '0;
        end else if (flush) begin
            r_rnData <= '0;
            r_rmData <= '0;
            r_imm    <= '0;
            r_rdAddr <= '0;
        end else if (!stall) begin
            r_rnData <= rn_data_in;
            r_rmData <= rm_data_in;
            r_imm    <= imm_in;
            r_rdAddr <= rd_addr_in;
        end
    end

    // Output decode: control is qualified by the valid state so a bubble can never write
    always_comb begin
        valid_out             = (r_state == FULL);
        reg_write_enable_out  = r_regWriteEnable && (r_state == FULL);
        mem_write_enable_out  = r_memWriteEnable && (r_state == FULL);
        mem_to_reg_select_out = r_memToRegSelect && (r_state == FULL);
        alu_src_select_out    = r_aluSrcSelect   && (r_state == FULL);
        pc_src_select_out     = r_pcSrcSelect    && (r_state == FULL);
        status_bits_out       = (r_state == FULL) ? r_statusBits : 2'b00;
        alu_control_out       = (r_state == FULL) ? r_aluControl : 2'b00;
        rn_data_out           = r_rnData;
        rm_data_out           = r_rmData;
        imm_out               = r_imm;
        rd_addr_out           = r_rdAddr;
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_WIDTH-1:0] r_bubbleCount;

    // Saturating count of bubbles loaded since reset; stall leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubbleCount <= '0;
        end else if (w_loadBubble && (r_bubbleCount != {CNT_WIDTH{1'b1}})) begin
            r_bubbleCount <= r_bubbleCount + 1'b1;
        end
    end

    assign bubble_count = r_bubbleCount;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg. Counter checks are compiled in
// only when ID_EX_BUBBLE_CNT_EN is defined (the DUT is then built with a
// 2-bit counter so saturation is reachable).
module tb_id_ex_pipe_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam int TB_CNT_WIDTH = 2;
`else
    localparam int TB_CNT_WIDTH = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic        reg_write_enable_in;
    logic        mem_write_enable_in;
    logic        mem_to_reg_select_in;
    logic        alu_src_select_in;
    logic        pc_src_select_in;
    logic [1:0]  status_bits_in;
    logic [1:0]  alu_control_in;
    logic [31:0] rn_data_in;
    logic [31:0] rm_data_in;
    logic [31:0] imm_in;
    logic [3:0]  rd_addr_in;
    logic        valid_out;
    logic        reg_write_enable_out;
    logic        mem_write_enable_out;
    logic        mem_to_reg_select_out;
    logic        alu_src_select_out;
    logic        pc_src_select_out;
    logic [1:0]  status_bits_out;
    logic [1:0]  alu_control_out;
    logic [31:0] rn_data_out;
    logic [31:0] rm_data_out;
    logic [31:0] imm_out;
    logic [3:0]  rd_addr_out;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [TB_CNT_WIDTH-1:0] bubble_count;
`endif

    int testCount = 0;
    int failCount = 0;

    id_ex_pipe_reg #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (4),
        .CNT_WIDTH      (TB_CNT_WIDTH)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall                 (stall),
        .flush                 (flush),
        .valid_in              (valid_in),
        .reg_write_enable_in   (reg_write_enable_in),
        .mem_write_enable_in   (mem_write_enable_in),
        .mem_to_reg_select_in  (mem_to_reg_select_in),
        .alu_src_select_in     (alu_src_select_in),
        .pc_src_select_in      (pc_src_select_in),
        .status_bits_in        (status_bits_in),
        .alu_control_in        (alu_control_in),
        .rn_data_in            (rn_data_in),
        .rm_data_in            (rm_data_in),
        .imm_in                (imm_in),
        .rd_addr_in            (rd_addr_in),
        .valid_out             (valid_out),
        .reg_write_enable_out  (reg_write_enable_out),
        .mem_write_enable_out  (mem_write_enable_out),
        .mem_to_reg_select_out (mem_to_reg_select_out),
        .alu_src_select_out    (alu_src_select_out),
        .pc_src_select_out     (pc_src_select_out),
        .status_bits_out       (status_bits_out),
        .alu_control_out       (alu_control_out),
        .rn_data_out           (rn_data_out),
        .rm_data_out           (rm_data_out),
        .imm_out               (imm_out),
        .rd_addr_out           (rd_addr_out)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_count          (bubble_count)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts the test and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and settle just after it
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Return every input to an idle value
    task automatic clearInputs();
        stall                = 1'b0;
        flush                = 1'b0;
        valid_in             = 1'b0;
        reg_write_enable_in  = 1'b0;
        mem_write_enable_in  = 1'b0;
        mem_to_reg_select_in = 1'b0;
        alu_src_select_in    = 1'b0;
        pc_src_select_in     = 1'b0;
        status_bits_in       = 2'b00;
        alu_control_in       = 2'b00;
        rn_data_in           = 32'h0;
        rm_data_in           = 32'h0;
        imm_in               = 32'h0;
        rd_addr_in           = 4'd0;
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0;
        clearInputs();
        #2;
        checkOutput("reset_valid",    32'(valid_out), 32'h0);
        checkOutput("reset_rwe",      32'(reg_write_enable_out), 32'h0);
        checkOutput("reset_rn",       rn_data_out, 32'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        checkOutput("reset_bubble",   32'(bubble_count), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Load a valid instruction, then assert reset between edges
        valid_in            = 1'b1;
        reg_write_enable_in = 1'b1;
        rn_data_in          = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("pre_rst_valid",  32'(valid_out), 32'h1);
        checkOutput("pre_rst_rwe",    32'(reg_write_enable_out), 32'h1);
        checkOutput("pre_rst_rn",     rn_data_out, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(valid_out), 32'h0);
        checkOutput("async_rst_rwe",   32'(reg_write_enable_out), 32'h0);
        checkOutput("async_rst_rn",    rn_data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clearInputs();

        // Plain load
        valid_in       = 1'b1;
        alu_control_in = 2'b10;
        rd_addr_in     = 4'd7;
        imm_in         = 32'h0000_00FF;
        applyStimulus();
        checkOutput("load_valid",     32'(valid_out), 32'h1);
        checkOutput("load_alu",       32'(alu_control_out), 32'h2);
        checkOutput("load_rd",        32'(rd_addr_out), 32'h7);
        checkOutput("load_imm",       imm_out, 32'hFF);

        // Stall for three edges while inputs move on
        @(negedge clk);
        stall      = 1'b1;
        rd_addr_in = 4'd3;
        imm_in     = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_rd",    32'(rd_addr_out), 32'h7);
            checkOutput("stall_imm",   imm_out, 32'hFF);
            checkOutput("stall_valid", 32'(valid_out), 32'h1);
        end
        @(negedge clk);
        stall = 1'b0;
        applyStimulus();
        checkOutput("unstall_rd",     32'(rd_addr_out), 32'h3);
        checkOutput("unstall_imm",    imm_out, 32'h55);

        // Flush together with stall: flush wins
        @(negedge clk);
        stall               = 1'b1;
        flush               = 1'b1;
        valid_in            = 1'b1;
        mem_write_enable_in = 1'b1;
        rn_data_in          = 32'hAAAA_0001;
        rm_data_in          = 32'hBBBB_0002;
        applyStimulus();
        checkOutput("flush_valid",    32'(valid_out), 32'h0);
        checkOutput("flush_mwe",      32'(mem_write_enable_out), 32'h0);
        checkOutput("flush_alu",      32'(alu_control_out), 32'h0);
        checkOutput("flush_rn",       rn_data_out, 32'h0);
        checkOutput("flush_rm",       rm_data_out, 32'h0);
        checkOutput("flush_imm",      imm_out, 32'h0);
        checkOutput("flush_rd",       32'(rd_addr_out), 32'h0);

        // Bubble load: data captured, control forced low
        @(negedge clk);
        stall               = 1'b0;
        flush               = 1'b0;
        valid_in            = 1'b0;
        mem_write_enable_in = 1'b0;
        reg_write_enable_in = 1'b1;
        pc_src_select_in    = 1'b1;
        rm_data_in          = 32'h0000_1234;
        applyStimulus();
        checkOutput("bubble_rwe",     32'(reg_write_enable_out), 32'h0);
        checkOutput("bubble_pcsrc",   32'(pc_src_select_out), 32'h0);
        checkOutput("bubble_valid",   32'(valid_out), 32'h0);
        checkOutput("bubble_rm",      rm_data_out, 32'h1234);
        checkOutput("bubble_rd",      32'(rd_addr_out), 32'h3);

        // Full control bundle on a valid load
        @(negedge clk);
        valid_in             = 1'b1;
        mem_to_reg_select_in = 1'b1;
        alu_src_select_in    = 1'b1;
        status_bits_in       = 2'b11;
        alu_control_in       = 2'b01;
        applyStimulus();
        checkOutput("ctrl_valid",     32'(valid_out), 32'h1);
        checkOutput("ctrl_rwe",       32'(reg_write_enable_out), 32'h1);
        checkOutput("ctrl_pcsrc",     32'(pc_src_select_out), 32'h1);
        checkOutput("ctrl_m2r",       32'(mem_to_reg_select_out), 32'h1);
        checkOutput("ctrl_alusrc",    32'(alu_src_select_out), 32'h1);
        checkOutput("ctrl_status",    32'(status_bits_out), 32'h3);
        checkOutput("ctrl_alu",       32'(alu_control_out), 32'h1);

`ifdef ID_EX_BUBBLE_CNT_EN
        // Counter: fresh reset, then 2 flushes, a stall, a bubble load, 2 more flushes
        @(negedge clk);
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("cnt_after_rst",  32'(bubble_count), 32'h0);
        flush = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("cnt_two_flush",  32'(bubble_count), 32'h2);
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        applyStimulus();
        checkOutput("cnt_stall_hold", 32'(bubble_count), 32'h2);
        @(negedge clk);
        stall    = 1'b0;
        valid_in = 1'b0;
        applyStimulus();
        checkOutput("cnt_bubble",     32'(bubble_count), 32'h3);
        @(negedge clk);
        flush = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("cnt_saturate",   32'(bubble_count), 32'h3);
        @(negedge clk);
        flush = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
